decode_stage: RTL and testbench



---
 rtl/decode_stage.sv | 161 ++++++++++++++++
 tb/tb_decode_stage.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: IF/ID register, decoder and load-use hazard unit feeding ID/EX; issue is 1 cycle after accept (2 with a bubble).
// Backpressure: id_ready drops on ex_stall, flush, a bubble or a held IF/ID. Define DECODE_STALL_COUNT_EN to add stall_count.
module decode_stage #(
   parameter int         DATA_W   = 16,
   parameter int         ADDR_W   = 3,
   parameter logic [4:0] OPC_LOAD = 5'b11001
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_valid,
   input  logic [DATA_W-1:0] if_instr,
   output logic              id_ready,
   input  logic              flush,
   input  logic              ex_stall,
   output logic [ADDR_W-1:0] rf_read_addr1,
   output logic [ADDR_W-1:0] rf_read_addr2,
   output logic              ex_valid,
   output logic [4:0]        ex_opcode,
   output logic [ADDR_W-1:0] ex_rd,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic [DATA_W-1:0] ex_imm
`ifdef DECODE_STALL_COUNT_EN
   ,
   output logic [15:0]       stall_count
`endif
);

   typedef enum logic [1:0] {S_DECODE, S_WAIT_IMM, S_BUBBLE} state_t;

   state_t            state_q;
   logic              ifid_vld_q;
   logic [DATA_W-1:0] ifid_instr_q;
   logic              imm_vld_q;
   logic [DATA_W-1:0] imm_q;
   logic              ex_valid_q;
   logic [4:0]        ex_opcode_q;
   logic [ADDR_W-1:0] ex_rd_q;
   logic              ex_reg_write_q;
   logic              ex_mem_read_q;
   logic [DATA_W-1:0] ex_imm_q;

   logic [4:0]        opc;
   logic [1:0]        cls;
   logic [ADDR_W-1:0] rd, rs1, rs2;
   logic              two_word, writes_rd, reads_rd, reads_rs1, reads_rs2;
   logic              hazard, can_issue, issue, accept, take_imm, take_word;
   logic              unused_lsbs;

   assign opc         = ifid_instr_q[15:11];
   assign rd          = ifid_instr_q[10:8];
   assign rs1         = ifid_instr_q[7:5];
   assign rs2         = ifid_instr_q[4:2];
   assign unused_lsbs = ^ifid_instr_q[1:0];
   assign cls         = opc[4:3];

   assign two_word  = (cls == 2'b11) && opc[2];
   assign writes_rd = (cls != 2'b00) && !((cls == 2'b11) && (opc[1:0] == 2'b10));
   // Memory/immediate class reads rs1 as its base register.
   assign reads_rd  = (cls == 2'b01);
   assign reads_rs1 = cls[1];
   assign reads_rs2 = (cls == 2'b10);

   assign hazard = ifid_vld_q && ex_valid_q && ex_mem_read_q &&
                   ((reads_rd  && (ex_rd_q == rd))  ||
                    (reads_rs1 && (ex_rd_q == rs1)) ||
                    (reads_rs2 && (ex_rd_q == rs2)));

   always_comb begin
      can_issue = 1'b0;
      case (state_q)
         S_DECODE:   can_issue = ifid_vld_q && !two_word && !hazard;
         S_WAIT_IMM: can_issue = imm_vld_q;
         S_BUBBLE:   can_issue = ifid_vld_q;
         default:    can_issue = 1'b0;
      endcase
   end

   // While waiting for an immediate the incoming word bypasses IF/ID.
   assign id_ready  = !flush && !ex_stall &&
                      ((state_q == S_WAIT_IMM) ||
                       ((state_q != S_BUBBLE) && !(ifid_vld_q && !can_issue)));
   assign accept    = if_valid && id_ready;
   assign take_imm  = accept && (state_q == S_WAIT_IMM) && !imm_vld_q;
   assign take_word = accept && !take_imm;
   assign issue     = !flush && !ex_stall && can_issue;

   assign rf_read_addr1 = ifid_vld_q ? (reads_rd ? rd : rs1) : '0;
   assign rf_read_addr2 = ifid_vld_q ? rs2 : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= S_DECODE;
         ifid_vld_q     <= 1'b0;
         ifid_instr_q   <= '0;
         imm_vld_q      <= 1'b0;
         imm_q          <= '0;
         ex_valid_q     <= 1'b0;
         ex_opcode_q    <= '0;
         ex_rd_q        <= '0;
         ex_reg_write_q <= 1'b0;
         ex_mem_read_q  <= 1'b0;
         ex_imm_q       <= '0;
      end else if (flush) begin
         state_q        <= S_DECODE;
         ifid_vld_q     <= 1'b0;
         imm_vld_q      <= 1'b0;
         ex_valid_q     <= 1'b0;
         ex_reg_write_q <= 1'b0;
         ex_mem_read_q  <= 1'b0;
      end else if (!ex_stall) begin
         if (take_imm) begin
            imm_q     <= if_instr;
            imm_vld_q <= 1'b1;
         end
         if (take_word) begin
            ifid_instr_q <= if_instr;
            ifid_vld_q   <= 1'b1;
         end else if (issue) begin
            ifid_vld_q <= 1'b0;
         end
         if (issue) begin
            state_q        <= S_DECODE;
            imm_vld_q      <= 1'b0;
            ex_valid_q     <= 1'b1;
            ex_opcode_q    <= opc;
            ex_rd_q        <= rd;
            ex_reg_write_q <= writes_rd;
            ex_mem_read_q  <= (opc == OPC_LOAD);
            ex_imm_q       <= two_word ? imm_q : '0;
         end else begin
            ex_valid_q     <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            if ((state_q == S_DECODE) && ifid_vld_q)
               state_q <= two_word ? S_WAIT_IMM : S_BUBBLE;
         end
      end
   end

   assign ex_valid     = ex_valid_q;
   assign ex_opcode    = ex_opcode_q;
   assign ex_rd        = ex_rd_q;
   assign ex_reg_write = ex_reg_write_q;
   assign ex_mem_read  = ex_mem_read_q;
   assign ex_imm       = ex_imm_q;

`ifdef DECODE_STALL_COUNT_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_cnt_q <= '0;
      else if (((state_q == S_BUBBLE) || (ex_stall && ifid_vld_q)) && (stall_cnt_q != 16'hFFFF))
         stall_cnt_q <= stall_cnt_q + 16'd1;
   end

   assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Randomised and directed bench for decode_stage against an in-order issue scoreboard.
module tb_decode_stage;

   localparam logic [4:0] OPC_LOAD = 5'b11001;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_valid;
   logic [15:0] if_instr;
   logic        id_ready;
   logic        flush;
   logic        ex_stall;
   logic [2:0]  rf_read_addr1, rf_read_addr2;
   logic        ex_valid;
   logic [4:0]  ex_opcode;
   logic [2:0]  ex_rd;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic [15:0] ex_imm;
`ifdef DECODE_STALL_COUNT_EN
   logic [15:0] stall_count;
`endif

   decode_stage dut (
      .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .id_ready(id_ready),
      .flush(flush), .ex_stall(ex_stall), .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
      .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_imm(ex_imm)
`ifdef DECODE_STALL_COUNT_EN
      , .stall_count(stall_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] instr;
      logic [15:0] imm;
      bit          two;
      bit          has_imm;
      bit          disturbed;
      int          exp_edge;
   } entry_t;

   entry_t      pend[$];
   bit          expect_imm;
   int          edge_n = 0;
   int          last_issue_edge = -10;
   logic [15:0] last_issue_instr = '0;
   bit          last_rdy, last_acc;
   logic        s_valid, s_rw, s_mr;
   logic [4:0]  s_op;
   logic [2:0]  s_rd;
   logic [15:0] s_imm;
   int          n_vec = 0, n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   // Architectural decode rules, written arithmetically.
   function automatic int f_cls(input logic [15:0] w);
      return int'(w[15:11]) / 8;
   endfunction

   function automatic bit f_two(input logic [15:0] w);
      return int'(w[15:11]) >= 28;
   endfunction

   function automatic bit f_writes(input logic [15:0] w);
      if (f_cls(w) == 0) return 1'b0;
      if (f_cls(w) == 3 && (int'(w[15:11]) % 4) == 2) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit f_reads(input logic [15:0] w, input logic [2:0] r);
      case (f_cls(w))
         1:       return w[10:8] == r;
         2:       return (w[7:5] == r) || (w[4:2] == r);
         3:       return w[7:5] == r;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] f_rf1(input logic [15:0] w);
      return (f_cls(w) == 1) ? w[10:8] : w[7:5];
   endfunction

   task automatic snapshot();
      s_valid = ex_valid; s_rw = ex_reg_write; s_mr = ex_mem_read;
      s_op = ex_opcode; s_rd = ex_rd; s_imm = ex_imm;
   endtask

   task automatic issue_check();
      entry_t e;
      check("issue_has_pending", 32'(pend.size() > 0), 1);
      if (pend.size() == 0) return;
      e = pend.pop_front();
      check("issue_imm_present", 32'(e.has_imm), 32'(e.two));
      check("ex_opcode", ex_opcode, e.instr[15:11]);
      check("ex_rd", ex_rd, e.instr[10:8]);
      check("ex_reg_write", ex_reg_write, f_writes(e.instr));
      check("ex_mem_read", ex_mem_read, e.instr[15:11] == OPC_LOAD);
      check("ex_imm", ex_imm, e.two ? e.imm : 16'h0);
      if (!e.disturbed) check("issue_latency", edge_n, e.exp_edge);
      last_issue_edge  = edge_n;
      last_issue_instr = e.instr;
   endtask

   task automatic accept_word(input logic [15:0] w);
      entry_t e;
      bit     hz;
      if (expect_imm) begin
         if (pend.size() > 0) begin
            pend[pend.size()-1].imm       = w;
            pend[pend.size()-1].has_imm   = 1'b1;
            pend[pend.size()-1].exp_edge  = edge_n + 1;
            pend[pend.size()-1].disturbed = 1'b0;
         end
         expect_imm = 1'b0;
      end else begin
         hz = (last_issue_edge == edge_n) && (last_issue_instr[15:11] == OPC_LOAD) &&
              f_reads(w, last_issue_instr[10:8]);
         e.instr = w; e.imm = '0; e.two = f_two(w); e.has_imm = 1'b0; e.disturbed = 1'b0;
         e.exp_edge = edge_n + 1 + int'(hz);
         pend.push_back(e);
         if (e.two) expect_imm = 1'b1;
      end
   endtask

   // One clock: drive at the negedge, then score the following posedge.
   task automatic step(input bit v, input logic [15:0] w, input bit s, input bit f);
      if_valid = v; if_instr = w; ex_stall = s; flush = f;
      #1;
      last_rdy = id_ready;
      if (s || f) check("rdy_blocked", id_ready, 0);
      if (pend.size() > 0) begin
         check("rf_addr1", rf_read_addr1, f_rf1(pend[0].instr));
         check("rf_addr2", rf_read_addr2, pend[0].instr[4:2]);
      end
      last_acc = v && id_ready;
      if (s || f) foreach (pend[i]) pend[i].disturbed = 1'b1;
      @(negedge clk);
      edge_n++;
      if (f) begin
         pend.delete();
         expect_imm = 1'b0;
         check("flush_ex_valid", ex_valid, 0);
      end else if (s) begin
         check("stall_hold_valid", ex_valid, s_valid);
         check("stall_hold_op", ex_opcode, s_op);
         check("stall_hold_rd", ex_rd, s_rd);
         check("stall_hold_imm", ex_imm, s_imm);
         check("stall_hold_ctl", {ex_reg_write, ex_mem_read}, {s_rw, s_mr});
      end else if (ex_valid) begin
         issue_check();
      end
      if (!ex_valid) check("bubble_ctl", {ex_reg_write, ex_mem_read}, 0);
      if (last_acc) accept_word(w);
      snapshot();
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 16'h0, 1'b0, 1'b0);
   endtask

   task automatic send(input logic [15:0] w);
      int tries = 0;
      do begin
         step(1'b1, w, 1'b0, 1'b0);
         tries++;
      end while (!last_acc && tries < 20);
      check("send_accepted", last_acc, 1);
   endtask

   task automatic do_reset();
      reset = 1'b1; if_valid = 1'b0; if_instr = '0; ex_stall = 1'b0; flush = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      pend.delete();
      expect_imm = 1'b0;
      last_issue_edge = -10;
      snapshot();
   endtask

   function automatic logic [15:0] rand_instr();
      logic [4:0] op;
      op = ($urandom_range(0, 3) == 0) ? OPC_LOAD : 5'($urandom_range(0, 31));
      return {op, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
              3'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      do_reset();
      #1;
      check("rst_ex_valid", ex_valid, 0);
      check("rst_id_ready", id_ready, 1);
      check("rst_rf1", rf_read_addr1, 0);
      check("rst_rf2", rf_read_addr2, 0);
      check("rst_ctl", {ex_reg_write, ex_mem_read}, 0);
      check("rst_fields", {ex_opcode, ex_rd, ex_imm}, 0);

      // Basic class-10 decode.
      send(16'b10000_011_001_010_00);
      check("t1_rf1", rf_read_addr1, 1);
      check("t1_rf2", rf_read_addr2, 2);
      idle(1);
      check("t1_valid", ex_valid, 1);
      check("t1_rd", ex_rd, 3);
      check("t1_rw", ex_reg_write, 1);
      check("t1_imm", ex_imm, 0);

      // Two-word instruction with idle gap before the immediate.
      send({5'b11100, 3'd5, 8'h00});
      idle(2);
      check("t2_wait", ex_valid, 0);
      send(16'hBEEF);
      check("t2_imm_edge", ex_valid, 0);
      idle(1);
      check("t2_valid", ex_valid, 1);
      check("t2_imm", ex_imm, 16'hBEEF);
      check("t2_rd", ex_rd, 5);

      // Load-use with a dependent rs1, then an independent one.
      send({OPC_LOAD, 3'd4, 8'h00});
      send({5'b10000, 3'd1, 3'd4, 3'd0, 2'b00});
      check("lu_load_in_ex", {ex_valid, ex_mem_read}, 2'b11);
      idle(1);
      check("lu_bubble", ex_valid, 0);
      check("lu_rdy_hazard", last_rdy, 0);
      idle(1);
      check("lu_rdy_bubble", last_rdy, 0);
      check("lu_issue", ex_valid, 1);
      check("lu_issue_rd", ex_rd, 1);
      send({OPC_LOAD, 3'd4, 8'h00});
      send({5'b10000, 3'd1, 3'd6, 3'd0, 2'b00});
      idle(1);
      check("nohz_issue", ex_valid, 1);
      check("nohz_rd", ex_rd, 1);

      // Three stall cycles with a word held in IF/ID.
      send({5'b10001, 3'd2, 3'd3, 3'd4, 2'b00});
      repeat (3) step(1'b1, {5'b01001, 3'd7, 8'h00}, 1'b1, 1'b0);
      check("stall_rdy", last_rdy, 0);
      send({5'b01001, 3'd7, 8'h00});
      idle(2);

      // Flush while waiting for an immediate.
      send({5'b11101, 3'd2, 8'h00});
      idle(1);
      step(1'b0, 16'h0, 1'b0, 1'b1);
      check("flush_wait_valid", ex_valid, 0);
      send({5'b01000, 3'd6, 8'h00});
      idle(1);
      check("flush_next_valid", ex_valid, 1);
      check("flush_next_op", ex_opcode, 5'b01000);
      check("flush_next_imm", ex_imm, 0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) != 0, rand_instr(),
              $urandom_range(0, 9) == 0, $urandom_range(0, 31) == 0);
      end
      if (expect_imm) send(16'h1234);
      idle(6);
      check("drain_empty", pend.size(), 0);

      // Asynchronous reset between clock edges.
      send({5'b10000, 3'd2, 3'd1, 3'd1, 2'b00});
      idle(1);
      check("ar_pre_valid", ex_valid, 1);
      #2 reset = 1'b1;
      #1 check("ar_async_valid", ex_valid, 0);
      check("ar_async_rf1", rf_read_addr1, 0);
      do_reset();

`ifdef DECODE_STALL_COUNT_EN
      check("sc_reset", stall_count, 0);
      send({OPC_LOAD, 3'd4, 8'h00});
      send({5'b10000, 3'd1, 3'd4, 3'd0, 2'b00});
      idle(2);
      send({OPC_LOAD, 3'd4, 8'h00});
      send({5'b10000, 3'd1, 3'd0, 3'd4, 2'b00});
      idle(2);
      send({5'b10000, 3'd2, 3'd1, 3'd1, 2'b00});
      repeat (3) step(1'b0, 16'h0, 1'b1, 1'b0);
      idle(2);
      check("sc_total", stall_count, 5);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
